fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the switch's packet-buffer FIFO.
- Generalised data width and depth. Uses the full 2**ADDR_W capacity, with no sacrificed slot (extra pointer wrap bit).
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and a compile-time first-word-fall-through (FWFT) read mode.
- Sits between port ingress logic and the switch arbiter, one instance per queue.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 2**ADDR_W-4, fifo_almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, fifo_almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of contents.
- write_data  in  DATA_W  write word.
- write_req  in  1  write request, level per cycle.
- read_req  in  1  read request (FWFT=1: pop acknowledge).
- read_data  out  DATA_W  read word.
- read_data_valid  out  1  read_data qualifier.
- fifo_of  out  1  overflow pulse.
- fifo_uf  out  1  underflow pulse.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- fifo_almost_full  out  1  count >= AF_LEVEL.
- fifo_almost_empty  out  1  count <= AE_LEVEL.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at clk edge):
  - Pointers, count, read_data, read_data_valid, fifo_of and fifo_uf go to 0.
  - fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0 (for AF_LEVEL>0).
  - Memory contents are not reset.
  - rst overrides flush and any request in the same cycle.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, wrapping naturally modulo 2**(ADDR_W+1).
  - Memory is indexed with the low ADDR_W bits.
  - fifo_count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Acceptance uses registered state at the start of the cycle:
  - wr_acc = write_req & !fifo_full.
  - rd_acc = read_req & !fifo_empty.
- Simultaneous events:
  - Read and write in the same cycle when not full and not empty: both accepted; count unchanged.
  - When full: the read is accepted, the write is rejected (no write-through).
  - When empty: the write is accepted, the read is rejected (no bypass).
- Overflow/underflow: fifo_of <= write_req & fifo_full; fifo_uf <= read_req & fifo_empty.
  - Registered, one-cycle pulse per offending cycle.
  - No state change on a rejected request.
- Status flags are combinational from the registered count. They update the cycle after the accepted op.
- FWFT=0 read path:
  - On rd_acc, read_data <= mem[rd_ptr] and read_data_valid <= 1, i.e. 1-cycle latency.
  - Otherwise read_data_valid <= 0 and read_data holds its last value.
- FWFT=1 read path:
  - read_data = mem[rd_ptr] (asynchronous read); read_data_valid = !fifo_empty.
  - read_req while valid pops the word.
  - A write into an empty FIFO is visible on read_data the cycle after acceptance.
- Flush (rst=0, flush=1):
  - Pointers and count go to 0, read_data_valid <= 0.
  - write_req and read_req in the flush cycle are ignored; fifo_of and fifo_uf <= 0.
- Parameter legality: require 0 < AE_LEVEL < AF_LEVEL <= DEPTH. Checked at elaboration (simulation-only check).

Decomposition:
- Shared package/header fifo_pkg: FIFO_DATA_W and FIFO_ADDR_W defaults, plus the threshold defaults.
- One sub-module, fifo_ram_sp: DEPTH x DATA_W array, synchronous write, read port selectable between registered and asynchronous by a parameter.
- Pointer, count, flag and read-valid logic stay in fifo_sync_param.

Test Plan:
- Reset, then write 0x01..0x10 (16 words), ADDR_W=4, FWFT=0:
  - fifo_full=1 and fifo_count=16 after the 16th write.
  - A 17th write gives fifo_of=1 for one cycle; count stays 16.
- From full, read 16 words, FWFT=0:
  - read_data is 0x01..0x10 in order, each with read_data_valid one cycle after read_req.
  - fifo_empty=1 after the last read; one more read_req gives fifo_uf=1.
- Half-full (count=8), write_req=read_req=1 for 40 cycles:
  - Count stays 8 and data order is preserved across pointer wrap (write 0xA0+i, read in the same order).
- AF_LEVEL=12, AE_LEVEL=4, fill one word at a time:
  - fifo_almost_empty drops at count 5.
  - fifo_almost_full rises at count 12 and falls when a read takes count to 11.
- FWFT=1, write 0x5A into empty FIFO:
  - Next cycle read_data=0x5A, read_data_valid=1.
  - read_req pops it; valid drops the following cycle.
- Count=9, assert flush together with write_req:
  - Next cycle fifo_count=0, fifo_empty=1, fifo_of=0.
  - A later rst=1 mid-stream restores all reset values in one cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and threshold legality helper for the switch queue FIFOs.
package fifo_pkg;
    localparam int FIFO_DATA_W    = 8;
    localparam int FIFO_ADDR_W    = 10;
    localparam int FIFO_AF_MARGIN = 4;
    localparam int FIFO_AF_LEVEL  = 2**FIFO_ADDR_W - FIFO_AF_MARGIN;
    localparam int FIFO_AE_LEVEL  = 4;

    function automatic bit fifo_levels_ok(input int ae, input int af, input int depth);
        return ae > 0 && ae < af && af <= depth;
    endfunction
endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: write/read handshake and status bundle between queue logic and the FIFO.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
);
    logic              flush;
    logic [DATA_W-1:0] write_data;
    logic              write_req;
    logic              read_req;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              fifo_of;
    logic              fifo_uf;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic              fifo_almost_empty;
    logic [ADDR_W:0]   fifo_count;

    modport master (
        output flush, write_data, write_req, read_req,
        input  read_data, read_data_valid, fifo_of, fifo_uf, fifo_empty, fifo_full,
               fifo_almost_full, fifo_almost_empty, fifo_count
    );
    modport slave (
        input  flush, write_data, write_req, read_req,
        output read_data, read_data_valid, fifo_of, fifo_uf, fifo_empty, fifo_full,
               fifo_almost_full, fifo_almost_empty, fifo_count
    );
endinterface

// File: rtl/fifo_ram_sp.sv
// fifo_ram_sp: DEPTH x DATA_W storage, synchronous write, registered or asynchronous read port.
module fifo_ram_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int REG_RD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

    if (REG_RD != 0) begin : g_reg
        logic [DATA_W-1:0] rdata_q, rdata_d;
        always_comb rdata_d = re ? mem[raddr] : rdata_q;
        always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
        assign rdata = rdata_q;
    end else begin : g_async
        logic unused_rd;
        assign unused_rd = rst ^ re;
        assign rdata     = mem[raddr];
    end
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock queue FIFO using all 2**ADDR_W slots via a wrap bit,
// with occupancy, programmable almost flags, flush and optional first-word-fall-through.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = 2**ADDR_W - FIFO_AF_MARGIN,
    parameter int AE_LEVEL = FIFO_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input logic               clk,
    input logic               rst,
    fifo_sync_param_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    if (!fifo_levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
        $error("fifo_sync_param: thresholds must satisfy 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic            rd_valid_q, rd_valid_d, of_q, of_d, uf_q, uf_d;
    logic            empty, full, wr_acc, rd_acc;

    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = count == '0;
    assign full   = count == (ADDR_W+1)'(DEPTH);
    assign wr_acc = bus.write_req & ~full & ~bus.flush;
    assign rd_acc = bus.read_req & ~empty & ~bus.flush;

    always_comb begin
        wr_ptr_d   = bus.flush ? '0 : wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_d   = bus.flush ? '0 : rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
        rd_valid_d = rd_acc;
        of_d       = bus.write_req & full & ~bus.flush;
        uf_d       = bus.read_req & empty & ~bus.flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
        end
    end

    // Non-FWFT reads land in the RAM's output register; FWFT exposes the head slot directly.
    fifo_ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_RD ((FWFT == 0) ? 1 : 0)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.write_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (bus.read_data)
    );

    assign bus.read_data_valid   = (FWFT != 0) ? ~empty : rd_valid_q;
    assign bus.fifo_of           = of_q;
    assign bus.fifo_uf           = uf_q;
    assign bus.fifo_empty        = empty;
    assign bus.fifo_full         = full;
    assign bus.fifo_almost_full  = count >= (ADDR_W+1)'(AF_LEVEL);
    assign bus.fifo_almost_empty = count <= (ADDR_W+1)'(AE_LEVEL);
    assign bus.fifo_count        = count;
endmodule
